// File: rtl/lynx_tape_pkg.sv
// Shared types and defaults for the Lynx cassette playback block.
`timescale 1ns/1ps
package lynx_tape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_SYNC,
    ST_DATA,
    ST_GAP
  } tape_state_t;

  localparam int HALF0_DEF  = 833;
  localparam int HALF1_DEF  = 1666;
  localparam int LEADER_DEF = 768;
  localparam int GAP_DEF    = 4000;

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lynx_tape_player_if.sv
// Byte stream handshake between the tape byte source and the player.
`timescale 1ns/1ps
interface lynx_tape_player_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;

  modport master (
    output data,
    output data_valid,
    output data_last,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    input  data_last,
    output data_ready
  );
endinterface

// File: rtl/lynx_tape_bitgen.sv
// One tape bit = one full ear cycle: high for HALFn ticks, then low for
// HALFn ticks. start loads a new bit and wins over hold; bit_done is high
// on the tick that ends the low half, so a new start can follow with no gap.
`timescale 1ns/1ps
module lynx_tape_bitgen
  import lynx_tape_pkg::*;
#(
  parameter int HALF0 = HALF0_DEF,
  parameter int HALF1 = HALF1_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic bit_val,
  input  logic start,
  input  logic hold,
  output logic ear,
  output logic bit_done
);

  localparam int CW = cnt_w(HALF1);

  logic          active;
  logic          phase;    // 0 = high half, 1 = low half
  logic          cur;      // bit value being emitted
  logic [CW-1:0] cnt;
  logic [CW-1:0] last_cnt;

  assign last_cnt = cur ? CW'(HALF1 - 1) : CW'(HALF0 - 1);
  assign bit_done = active && ce && !hold && phase && (cnt == last_cnt);
  assign ear      = active && !phase;

  // Half-period counter and phase; frozen by hold, reloaded by start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      phase  <= 1'b0;
      cur    <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      phase  <= 1'b0;
      cur    <= bit_val;
      cnt    <= '0;
    end else if (active && ce && !hold) begin
      if (cnt == last_cnt) begin
        cnt   <= '0;
        phase <= !phase;
        if (phase) active <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lynx_tape_player.sv
// Cassette playback for the Lynx ear input: leader of 0-bits, one 1-bit
// sync, then bytes MSB first pulled from a valid/ready byte stream, then a
// low gap and an end-of-block pulse.
`timescale 1ns/1ps
module lynx_tape_player
  import lynx_tape_pkg::*;
#(
  parameter int HALF0  = HALF0_DEF,
  parameter int HALF1  = HALF1_DEF,
  parameter int LEADER = LEADER_DEF,
  parameter int GAP    = GAP_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              play,
  input  logic              motor,
  lynx_tape_player_if.slave tape,
  output logic              ear,
  output logic              busy,
  output logic              eob
);

  localparam int LCW = cnt_w(LEADER + 1);
  localparam int GCW = cnt_w(GAP + 1);

  tape_state_t    state, state_n;
  logic [LCW-1:0] lcnt, lcnt_n;
  logic [GCW-1:0] gcnt, gcnt_n;
  logic [7:0]     shreg, shreg_n;
  logic [2:0]     bitcnt, bitcnt_n;
  logic           last_q, last_n;
  logic           wait_q, wait_n;   // byte boundary reached with no data

  logic bg_start, bg_bit, bg_hold, bg_ear, bg_done;
  logic rdy, eob_c, take;

  // IDLE parks the bit generator; motor off freezes it mid-tick.
  assign bg_hold = (state == ST_IDLE) || !motor;

  lynx_tape_bitgen #(
    .HALF0 (HALF0),
    .HALF1 (HALF1)
  ) u_bitgen (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .bit_val  (bg_bit),
    .start    (bg_start),
    .hold     (bg_hold),
    .ear      (bg_ear),
    .bit_done (bg_done)
  );

  // Next-state, byte handshake and bit sequencing.
  always_comb begin
    state_n  = state;
    lcnt_n   = lcnt;
    gcnt_n   = gcnt;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    last_n   = last_q;
    wait_n   = wait_q;
    bg_start = 1'b0;
    bg_bit   = 1'b0;
    rdy      = 1'b0;
    eob_c    = 1'b0;
    take     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (play && motor && ce && tape.data_valid) begin
          state_n  = ST_LEADER;
          lcnt_n   = LCW'(LEADER);
          bg_start = 1'b1;
        end
      end
      ST_LEADER: begin
        if (bg_done) begin
          bg_start = 1'b1;
          if (lcnt == LCW'(1)) begin
            state_n = ST_SYNC;
            lcnt_n  = '0;
            bg_bit  = 1'b1;
          end else begin
            lcnt_n = lcnt - LCW'(1);
          end
        end
      end
      ST_SYNC: begin
        if (bg_done) begin
          state_n = ST_DATA;
          take    = 1'b1;
        end
      end
      ST_DATA: begin
        if (wait_q) begin
          take = ce && motor;
        end else if (bg_done) begin
          if (bitcnt != 3'd0) begin
            // Rotate so the next bit to emit sits in bit 7.
            bitcnt_n = bitcnt - 3'd1;
            shreg_n  = {shreg[6:0], shreg[7]};
            bg_start = 1'b1;
            bg_bit   = shreg[6];
          end else if (last_q) begin
            state_n = ST_GAP;
            gcnt_n  = '0;
          end else begin
            take = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gcnt == GCW'(GAP)) begin
          eob_c   = 1'b1;
          state_n = ST_IDLE;
          gcnt_n  = '0;
        end else if (ce && motor) begin
          gcnt_n = gcnt + GCW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Byte boundary: accept the next byte, or stall with ear low.
    if (take) begin
      if (tape.data_valid) begin
        rdy      = 1'b1;
        shreg_n  = tape.data;
        bitcnt_n = 3'd7;
        last_n   = tape.data_last;
        wait_n   = 1'b0;
        bg_start = 1'b1;
        bg_bit   = tape.data[7];
      end else begin
        wait_n = 1'b1;
      end
    end

    // Dropping play abandons everything, including a partial byte.
    if (!play) begin
      state_n  = ST_IDLE;
      bg_start = 1'b0;
      rdy      = 1'b0;
      eob_c    = 1'b0;
      wait_n   = 1'b0;
    end
  end

  // State and sequencing registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      lcnt   <= '0;
      gcnt   <= '0;
      shreg  <= 8'h00;
      bitcnt <= 3'd0;
      last_q <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      state  <= state_n;
      lcnt   <= lcnt_n;
      gcnt   <= gcnt_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      last_q <= last_n;
      wait_q <= wait_n;
    end
  end

  assign ear             = bg_ear && (state != ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign eob             = eob_c;
  assign tape.data_ready = rdy;

endmodule

// File: doc/lynx_tape_player.md
LYNX_TAPE_PLAYER -- requirements
Module: lynx_tape_player

Interface
REQ-001 Parameter HALF0, default 833: half-period of a 0-bit, in ce ticks (about 2.4 kHz at a 4 MHz ce).
REQ-002 Parameter HALF1, default 1666: half-period of a 1-bit, in ce ticks.
REQ-003 Parameter LEADER, default 768: number of 0-bit cycles in the leader before sync.
REQ-004 Parameter GAP, default 4000: number of ce ticks of low output after the block's last bit.
REQ-005 Port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port ce, input, 1: tick enable; every timing counter advances only when ce is high.
REQ-008 Port play, input, 1: level; high enables playback.
REQ-009 Port motor, input, 1: cassette motor bit from port 0x80 bit 1; low pauses playback.
REQ-010 Port data, input, 8: next tape byte.
REQ-011 Port data_valid, input, 1: data and data_last are valid.
REQ-012 Port data_last, input, 1: the current byte is the last byte of the block.
REQ-013 Port data_ready, output, 1: byte accepted on a clock where data_ready and data_valid are both high.
REQ-014 Port ear, output, 1: generated tape waveform, fed to the ear path.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port eob, output, 1: one-clock pulse when GAP completes.

Function
REQ-017 States: IDLE, LEADER, SYNC, DATA, GAP.
REQ-018 IDLE -> LEADER when play=1, motor=1 and data_valid=1; leader count loads LEADER.
REQ-019 Each bit is one full cycle of ear: high for HALFn ticks, then low for HALFn ticks. n is the bit value.
REQ-020 LEADER emits LEADER 0-bits, then goes to SYNC.
REQ-021 SYNC emits exactly one 1-bit, then goes to DATA.
REQ-022 DATA handshake: data_ready is high for exactly one clock at each byte boundary, and only while data_valid=1.
  - The accepted byte loads an 8-bit shift register; bits are emitted MSB first.
  - data_last is latched with the byte.
REQ-023 The first byte is accepted on the SYNC -> DATA transition.
  - Each following byte is accepted on the clock that ends the previous byte's final low half.
  - There are no inter-byte gaps.
REQ-024 Underrun: if data_valid=0 at a byte boundary, ear is held at 0 and counters are frozen until data_valid=1. Emission then resumes with a fresh bit.
REQ-025 After the final bit of a byte accepted with data_last=1, the state goes to GAP, ear=0, and GAP ticks are counted.
REQ-026 At the end of GAP: eob pulses for one clock, then GAP -> IDLE.
REQ-027 motor=0 in any non-IDLE state freezes all counters and holds ear at its current level. motor=1 resumes from the same tick.
REQ-028 play=0 in any state forces IDLE on the next clock, with ear=0.
  - No eob pulse is generated.
  - A partially emitted byte is discarded and is not re-requested.
REQ-029 A half-period counter reaching HALFn-1 on a ce tick toggles the phase and reloads to 0. Counter width is clog2(HALF1).
REQ-030 When ce=0, nothing changes except the play=0 abort and the data_ready/eob single-clock pulses.

Reset
REQ-031 Asynchronous reset (reset=0) forces: state IDLE, ear=0, data_ready=0, busy=0, eob=0, all counters 0, shift register 0x00.
REQ-032 Reset asserted mid-byte abandons the byte. After release the block waits in IDLE for a new start condition.

Structure
REQ-033 Package lynx_tape_pkg holds:
  - the state enumeration;
  - default constants HALF0_DEF, HALF1_DEF, LEADER_DEF, GAP_DEF;
  - the counter-width helper.
REQ-034 One sub-module, lynx_tape_bitgen, takes clock, reset, ce, bit value, start and hold, and returns ear and bit_done.
  - Leader, sync and data bits all use lynx_tape_bitgen.

Verification
Bench parameters: HALF0=4, HALF1=8, LEADER=4, GAP=10, ce high every clock.
REQ-035 Byte 0xA5 with last=1, play=1, motor=1 -> ear shows:
  - 4 cycles of period 8;
  - 1 cycle of period 16;
  - bits 1,0,1,0,0,1,0,1;
  - 10 low ticks, then eob for 1 clock;
  - busy=0 on the following clock.
REQ-036 Bytes 0x00 then 0xFF (last on the second) supplied back-to-back -> data_ready pulses twice, 64 clocks apart at the byte boundary. The data bits total 192 clocks.
REQ-037 data_valid dropped for 20 clocks after the first byte -> ear stays 0 for those 20 clocks. The second byte then starts with a full high half.
REQ-038 motor=0 for 7 clocks mid-way through a 1-bit high half -> ear stays 1, and the bit completes 7 clocks late.
REQ-039 play=0 during DATA -> next clock state IDLE, ear=0, eob never asserted.
REQ-040 reset=0 pulse during LEADER -> all outputs 0 immediately, without waiting for a clock edge.
